// File: rtl/gpr_wb_scheduler_if.sv
// Bundle of write-back request, issue, register-file and hazard-check signals
// shared between the write-back scheduler and its environment.
interface gpr_wb_scheduler_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
);
    logic              a_valid;
    logic [2:0]        a_dest;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [2:0]        b_dest;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              issue_valid;
    logic [2:0]        issue_dest;
    logic              issue_ready;
    logic              reg_write;
    logic [2:0]        reg_write_dest;
    logic [DATA_W-1:0] reg_write_data;
    logic [2:0]        chk_addr_1;
    logic [2:0]        chk_addr_2;
    logic              hazard_1;
    logic              hazard_2;
    logic [NREG-1:0]   busy;
    logic              err_underflow;

    modport slave (
        input  a_valid, a_dest, a_data, b_valid, b_dest, b_data,
        input  issue_valid, issue_dest, chk_addr_1, chk_addr_2,
        output a_ready, b_ready, issue_ready, reg_write, reg_write_dest,
        output reg_write_data, hazard_1, hazard_2, busy, err_underflow
    );

    modport master (
        output a_valid, a_dest, a_data, b_valid, b_dest, b_data,
        output issue_valid, issue_dest, chk_addr_1, chk_addr_2,
        input  a_ready, b_ready, issue_ready, reg_write, reg_write_dest,
        input  reg_write_data, hazard_1, hazard_2, busy, err_underflow
    );
endinterface

// File: rtl/gpr_wb_scheduler.sv
// Round-robin arbiter between two write-back requesters with per-register
// pending-write scoreboard, hazard lookup and sticky underflow flag.
module gpr_wb_scheduler #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int CNT_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    gpr_wb_scheduler_if.slave  bus
);
    localparam logic [0:0] PTR_A = 1'b0;
    localparam logic [0:0] PTR_B = 1'b1;

    logic [0:0]                  r_ptr;
    logic                        r_wr;
    logic [2:0]                  r_wr_dest;
    logic [DATA_W-1:0]           r_wr_data;
    logic                        r_err;

    logic                        w_grant_a;
    logic                        w_grant_b;
    logic                        w_ret;
    logic [2:0]                  w_ret_dest;
    logic [DATA_W-1:0]           w_ret_data;
    logic                        w_cnt_full;
    logic                        w_issue_ready;
    logic                        w_issue_acc;
    logic [NREG-1:0][CNT_W-1:0]  w_cnt;
    logic [NREG-1:0]             w_busy;
    logic [NREG-1:0]             w_uf;

    // Grants are masked during reset so nothing is accepted while rst is high.
    always_comb begin
        w_grant_a  = !rst && bus.a_valid && (!bus.b_valid || r_ptr == PTR_A);
        w_grant_b  = !rst && bus.b_valid && (!bus.a_valid || r_ptr == PTR_B);
        w_ret      = w_grant_a || w_grant_b;
        w_ret_dest = w_grant_b ? bus.b_dest : bus.a_dest;
        w_ret_data = w_grant_b ? bus.b_data : bus.a_data;
    end

    // A full counter can still take an issue if the same register retires now.
    always_comb begin
        w_cnt_full    = (w_cnt[bus.issue_dest] == {CNT_W{1'b1}});
        w_issue_ready = !rst && (!w_cnt_full || (w_ret && w_ret_dest == bus.issue_dest));
        w_issue_acc   = bus.issue_valid && w_issue_ready;
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            logic             w_inc;
            logic             w_dec;

            assign w_inc = w_issue_acc && (bus.issue_dest == 3'(gi));
            assign w_dec = w_ret && (w_ret_dest == 3'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_inc && !w_dec) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (w_dec && !w_inc && r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign w_cnt[gi]  = r_cnt;
            assign w_busy[gi] = |r_cnt;
            assign w_uf[gi]   = w_dec && !w_inc && (r_cnt == '0);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= PTR_A;
            r_wr      <= 1'b0;
            r_wr_dest <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_grant_a) begin
                r_ptr <= PTR_B;
            end else if (w_grant_b) begin
                r_ptr <= PTR_A;
            end
            r_wr <= w_ret;
            if (w_ret) begin
                r_wr_dest <= w_ret_dest;
                r_wr_data <= w_ret_data;
            end
            r_err <= r_err | (|w_uf);
        end
    end

    assign bus.a_ready        = w_grant_a;
    assign bus.b_ready        = w_grant_b;
    assign bus.issue_ready    = w_issue_ready;
    assign bus.reg_write      = r_wr;
    assign bus.reg_write_dest = r_wr_dest;
    assign bus.reg_write_data = r_wr_data;
    assign bus.busy           = w_busy;
    assign bus.hazard_1       = w_busy[bus.chk_addr_1];
    assign bus.hazard_2       = w_busy[bus.chk_addr_2];
    assign bus.err_underflow  = r_err;
endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// Bench for gpr_wb_scheduler: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_gpr_wb_scheduler;
    logic clk;
    logic rst;

    gpr_wb_scheduler_if #(.DATA_W(16), .NREG(8)) bus ();

    gpr_wb_scheduler #(.DATA_W(16), .NREG(8), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: outstanding writes per register, whose turn it is on a tie,
    // and the write the register file should be seeing right now.
    int          m_cnt [8];
    bit          m_turn_b;
    bit          m_wr;
    logic [2:0]  m_dest;
    logic [15:0] m_data;
    bit          m_err;

    logic s_a_ready, s_b_ready, s_issue_ready, s_haz1, s_haz2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_turn_b = 1'b0;
        m_wr     = 1'b0;
        m_dest   = '0;
        m_data   = '0;
        m_err    = 1'b0;
    endtask

    function automatic logic [7:0] model_busy();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic idle_inputs();
        bus.a_valid = 0; bus.a_dest = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_dest = 0; bus.b_data = 0;
        bus.issue_valid = 0; bus.issue_dest = 0;
        bus.chk_addr_1 = 0; bus.chk_addr_2 = 0;
    endtask

    // Entered 1 time unit after a rising edge; returns 1 unit after the next one.
    task automatic cycle(input bit av, input logic [2:0] ad, input logic [15:0] adat,
                         input bit bv, input logic [2:0] bd, input logic [15:0] bdat,
                         input bit iv, input logic [2:0] id,
                         input logic [2:0] c1, input logic [2:0] c2);
        bit ga, gb, ret, acc, exp_ir;
        logic [2:0] rd;
        logic [15:0] rdat;
        bus.a_valid = av; bus.a_dest = ad; bus.a_data = adat;
        bus.b_valid = bv; bus.b_dest = bd; bus.b_data = bdat;
        bus.issue_valid = iv; bus.issue_dest = id;
        bus.chk_addr_1 = c1; bus.chk_addr_2 = c2;
        #3;
        chk("reg_write", bus.reg_write, m_wr);
        if (m_wr) begin
            chk("reg_write_dest", bus.reg_write_dest, m_dest);
            chk("reg_write_data", bus.reg_write_data, m_data);
        end
        chk("busy", bus.busy, model_busy());
        chk("err_underflow", bus.err_underflow, m_err);

        ga   = av && (!bv || !m_turn_b);
        gb   = bv && (!av || m_turn_b);
        ret  = ga || gb;
        rd   = gb ? bd : ad;
        rdat = gb ? bdat : adat;
        exp_ir = (m_cnt[id] < 3) || (ret && rd == id);
        acc  = iv && exp_ir;

        chk("a_ready", bus.a_ready, ga);
        chk("b_ready", bus.b_ready, gb);
        chk("issue_ready", bus.issue_ready, exp_ir);
        chk("hazard_1", bus.hazard_1, m_cnt[c1] != 0);
        chk("hazard_2", bus.hazard_2, m_cnt[c2] != 0);
        s_a_ready = bus.a_ready; s_b_ready = bus.b_ready;
        s_issue_ready = bus.issue_ready;
        s_haz1 = bus.hazard_1; s_haz2 = bus.hazard_2;
        if (ret) $display("wb %s r%0d data=%h", ga ? "A" : "B", rd, rdat);

        if (!(acc && ret && id == rd)) begin
            if (acc) m_cnt[id]++;
            if (ret) begin
                if (m_cnt[rd] == 0) m_err = 1'b1;
                else m_cnt[rd]--;
            end
        end
        if (ga) m_turn_b = 1'b1;
        if (gb) m_turn_b = 1'b0;
        m_wr = ret;
        if (ret) begin
            m_dest = rd;
            m_data = rdat;
        end
        @(posedge clk);
        #1;
    endtask

    // Raises rst mid-cycle with requests pending, checks the immediate effect.
    task automatic do_reset();
        rst = 1'b1;
        bus.a_valid = 1; bus.b_valid = 1; bus.issue_valid = 1;
        #1;
        chk("rst_reg_write", bus.reg_write, 1'b0);
        chk("rst_dest", bus.reg_write_dest, 3'd0);
        chk("rst_data", bus.reg_write_data, 16'd0);
        chk("rst_busy", bus.busy, 8'd0);
        chk("rst_err", bus.err_underflow, 1'b0);
        chk("rst_readies", {bus.a_ready, bus.b_ready, bus.issue_ready}, 3'b000);
        chk("rst_hazards", {bus.hazard_1, bus.hazard_2}, 2'b00);
        model_reset();
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Round robin under continuous contention: A,B,A,B.
        begin
            logic [3:0] g;
            for (int k = 0; k < 4; k++) begin
                cycle(1, 3'd1, 16'h1111 + 16'(k), 1, 3'd2, 16'h2222 + 16'(k), 0, 0, 0, 0);
                g[3-k] = s_a_ready;
                if (k == 0) chk("lit_first_data", bus.reg_write_data, 16'h1111);
            end
            chk("lit_rr_seq", g, 4'b1010);
        end
        idle();

        // Simple issue then A write to r3.
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 1, 3'd3, 0, 0);
        chk("lit_busy3_set", bus.busy[3], 1'b1);
        cycle(1, 3'd3, 16'hABCD, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_a_ready", s_a_ready, 1'b1);
        chk("lit_wr", {bus.reg_write, bus.reg_write_dest, bus.reg_write_data}, {1'b1, 3'd3, 16'hABCD});
        chk("lit_busy3_clr", bus.busy[3], 1'b0);
        idle();

        // Saturation of r5 and retire-bypass of the full check.
        do_reset();
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 0, 1, 3'd5, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 3'd5, 0, 0);
        chk("lit_full_block", s_issue_ready, 1'b0);
        cycle(0, 0, 0, 1, 3'd5, 16'h5555, 1, 3'd5, 0, 0);
        chk("lit_full_bypass", s_issue_ready, 1'b1);
        cycle(0, 0, 0, 0, 0, 0, 1, 3'd5, 0, 0);
        chk("lit_still_full", s_issue_ready, 1'b0);

        // Underflow on r2.
        do_reset();
        cycle(0, 0, 0, 1, 3'd2, 16'h0202, 0, 0, 0, 0);
        chk("lit_uf_write", bus.reg_write, 1'b1);
        chk("lit_uf_err", bus.err_underflow, 1'b1);
        chk("lit_uf_busy2", bus.busy[2], 1'b0);
        idle();
        chk("lit_uf_sticky", bus.err_underflow, 1'b1);

        // Hazard lifetime on r1.
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 1, 3'd1, 3'd1, 0);
        cycle(1, 3'd1, 16'h0101, 0, 0, 0, 0, 0, 3'd1, 0);
        chk("lit_haz_grant", s_haz1, 1'b1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0);
        chk("lit_haz_clear", s_haz1, 1'b0);

        // Asynchronous reset one cycle after a grant.
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 1, 3'd4, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 3'd6, 0, 0);
        cycle(1, 3'd4, 16'h4444, 1, 3'd6, 16'h6666, 0, 0, 0, 0);
        chk("lit_pre_rst_wr", bus.reg_write, 1'b1);
        chk("lit_pre_rst_busy", bus.busy, 8'h40);
        do_reset();
        cycle(1, 3'd0, 16'h0A0A, 1, 3'd7, 16'h0B0B, 0, 0, 0, 0);
        chk("lit_post_rst_a", s_a_ready, 1'b1);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), 16'($urandom),
                      $urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), 16'($urandom),
                      $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/gpr_wb_scheduler.md
GPR_WB_SCHEDULER -- requirements
Module: gpr_wb_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning write-data width.
REQ-002 SHALL have parameter NREG, default 8, meaning register count; address width is 3.
REQ-003 SHALL have parameter CNT_W, default 2, meaning width of the per-register pending counter.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 a_valid/a_dest/a_data  in  1/3/DATA_W  requester A (ALU) write-back request.
REQ-007 a_ready  out  1  A request accepted this cycle.
REQ-008 b_valid/b_dest/b_data  in  1/3/DATA_W  requester B (load unit) write-back request.
REQ-009 b_ready  out  1  B request accepted this cycle.
REQ-010 issue_valid/issue_dest  in  1/3  decode announces a future write to issue_dest.
REQ-011 issue_ready  out  1  issue accepted this cycle.
REQ-012 reg_write/reg_write_dest/reg_write_data  out  1/3/DATA_W  register-file write port.
REQ-013 chk_addr_1/chk_addr_2  in  3/3  source registers to hazard-check.
REQ-014 hazard_1/hazard_2  out  1/1  addressed register has a pending write.
REQ-015 busy  out  NREG  per-register pending flag (count != 0).
REQ-016 err_underflow  out  1  sticky: write retired to a register with no pending issue.

Function
REQ-017 SHALL compute grants combinationally: only one valid -> grant it; both valid -> grant the side named by the round-robin pointer; a_ready/b_ready equal the grants.
REQ-018 SHALL move the pointer to the non-granted side after every grant; with no grant, the pointer holds.
REQ-019 SHALL register the granted dest/data to reg_write_dest/reg_write_data with reg_write=1 on the edge after the grant (1-cycle latency).
REQ-020 SHALL drive reg_write=0 in cycles with no grant in the previous cycle; dest/data hold their last value.
REQ-021 SHALL keep a CNT_W-bit pending count per register: +1 on an accepted issue, -1 on a granted write to that register.
REQ-022 SHALL deassert issue_ready when count[issue_dest]==2^CNT_W-1, except when the same register retires in the same cycle.
REQ-023 SHALL leave the count unchanged when an issue and a retire hit the same register in the same cycle.
REQ-024 SHALL hold a count at 0 when a retire hits a register whose count is already 0, and set err_underflow; the write is still performed.
REQ-025 SHALL compute hazard_n = busy[chk_addr_n] combinationally from the current (pre-edge) counts; a retire granted this cycle still reports a hazard.
REQ-026 SHALL keep err_underflow set until reset.
REQ-027 SHALL treat register 0 like any other register (no hardwired zero).

Reset
REQ-028 While rst=1, SHALL immediately force reg_write=0, reg_write_dest=0, reg_write_data=0, all counts=0, busy=0, hazards=0, err_underflow=0, and pointer=A.
REQ-029 While rst=1, SHALL force a_ready=0, b_ready=0 and issue_ready=0; requests in flight are discarded.
REQ-030 Reset asserted mid-operation SHALL cancel a write that was registered but not yet presented; the first cycle after release has reg_write=0.

Verification
REQ-031 Issue r3, then a_valid with dest=3, data=16'hABCD -> a_ready=1; next cycle reg_write=1, dest=3, data=ABCD; busy[3] 1->0 at the same edge.
REQ-032 a_valid and b_valid held together for 4 cycles after reset -> grants A,B,A,B; writes appear one cycle after each grant.
REQ-033 Issue r5 three times -> issue_ready=0 for a 4th r5 issue; the same cycle with a B write to r5 -> issue accepted, count stays 3.
REQ-034 B write to r2 with count[2]=0 -> reg_write occurs, err_underflow=1 and stays set; busy[2]=0.
REQ-035 Issue r1, chk_addr_1=1 -> hazard_1=1; in the grant cycle of the r1 write, hazard_1 is still 1; the next cycle hazard_1=0.
REQ-036 Assert rst asynchronously one cycle after a grant -> reg_write=0 immediately, busy=0; after release, the first request is granted to A when both are valid.
